spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of spike channels (spike_1, spike_2, spike_3, spike_output).
REQ-002 SHALL have parameter CNT_W, default 6, meaning the per-channel spike counter width.
REQ-003 SHALL have parameter WIN_W, default 8, meaning the observation-window length width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port spike_in, input, NCH bits: one spike pulse per channel; bit 0 = neuron 1, bit 3 = output neuron.
REQ-007 SHALL have port window_len, input, WIN_W bits: number of cycles to count, sampled at start.
REQ-008 SHALL have port start, input, 1 bit: request a measurement window.
REQ-009 SHALL have port busy, output, 1 bit: high in COUNT and REPORT.
REQ-010 SHALL have port result_valid, output, 1 bit: results are presented.
REQ-011 SHALL have port result_ready, input, 1 bit: consumer accepts results.
REQ-012 SHALL have port counts, output, NCH*CNT_W bits: channel i count in bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port winner, output, 2 bits: index of the channel with the highest count.
REQ-014 SHALL have port winner_valid, output, 1 bit: at least one count is nonzero.
REQ-015 SHALL have port overflow, output, NCH bits: per-channel saturation flag.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, COUNT, REPORT.
REQ-017 SHALL, in IDLE with start=1 and window_len!=0, capture window_len, clear all counts and overflow, and enter COUNT on the next edge.
REQ-018 SHALL ignore start when window_len=0 (stay in IDLE) and ignore start in COUNT and REPORT.
REQ-019 SHALL count spike_in in exactly window_len consecutive COUNT cycles; the spike present in the start cycle is not counted.
REQ-020 SHALL increment each channel's count by 1 per COUNT cycle in which its spike_in bit is 1, independently per channel.
REQ-021 SHALL saturate each count at 2^CNT_W-1 and set that channel's overflow bit on any spike arriving while the count is saturated.
REQ-022 SHALL enter REPORT after the last counted cycle; for a start sampled at edge t, result_valid rises after edge t+window_len+1.
REQ-023 SHALL register winner and winner_valid on entry to REPORT: winner = channel with the maximum count; ties resolve to the lowest index; if all counts are 0, winner=0 and winner_valid=0.
REQ-024 SHALL hold result_valid, counts, winner, winner_valid and overflow stable in REPORT until a cycle with result_ready=1, then return to IDLE.
REQ-025 SHALL keep counts, winner and overflow at their last values in IDLE until the next accepted start.
REQ-026 SHALL not accept start in the handshake cycle; a new window requires start in IDLE.
REQ-027 SHALL drive busy=1 exactly when the state is COUNT or REPORT.

Reset
REQ-028 SHALL, while reset=1 at any time (including mid-window), force state IDLE, busy=0, result_valid=0, counts=0, winner=0, winner_valid=0, overflow=0 and the window counter to 0.
REQ-029 SHALL treat a start asserted in the first edge after reset release like any other IDLE start.

Structure
REQ-030 SHALL place the FSM state encoding and the default NCH/CNT_W/WIN_W values in the shared project package.
REQ-031 SHALL instantiate one sub-module per channel, spike_counter: a saturating CNT_W counter with clear, increment enable, and overflow flag, reset by the same asynchronous active-high reset.

Verification
REQ-032 SHALL verify: window_len=10, spike_in=4'b0001 every cycle -> counts[0]=10, others 0, winner=0, winner_valid=1, result_valid after edge t+11.
REQ-033 SHALL verify: window_len=8, channel 1 spikes 3 times, channel 2 spikes 3 times, channel 3 spikes once -> winner=1 (tie to lowest index), counts[1]=counts[2]=3.
REQ-034 SHALL verify: window_len=100, channel 3 spikes every cycle, CNT_W=6 -> counts[3]=63, overflow=4'b1000.
REQ-035 SHALL verify: result_ready held 0 for 5 cycles in REPORT with start pulses -> outputs stable, no new window; result_ready=1 -> IDLE next edge.
REQ-036 SHALL verify: reset asserted at cycle 4 of a 20-cycle window -> all outputs 0 immediately, IDLE; a subsequent start with window_len=0 -> busy stays 0.
REQ-037 SHALL verify: window_len=5, no spikes -> winner_valid=0, winner=0, counts all 0.

Source files
------------

// File: rtl/spike_rate_decoder_pkg.sv
// spike_rate_decoder_pkg: shared FSM encoding and default sizing for the spike rate decoder.
package spike_rate_decoder_pkg;
  localparam int DEF_NCH = 4;
  localparam int DEF_CNT_W = 6;
  localparam int DEF_WIN_W = 8;
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
endpackage

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: spike inputs, window control and result handshake of the decoder.
interface spike_rate_decoder_if
  import spike_rate_decoder_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
);
  logic [NCH-1:0] spike_in;
  logic [WIN_W-1:0] window_len;
  logic start;
  logic busy;
  logic result_valid;
  logic result_ready;
  logic [NCH*CNT_W-1:0] counts;
  logic [1:0] winner;
  logic winner_valid;
  logic [NCH-1:0] overflow;
  modport master (
    output spike_in, window_len, start, result_ready,
    input busy, result_valid, counts, winner, winner_valid, overflow
  );
  modport slave (
    input spike_in, window_len, start, result_ready,
    output busy, result_valid, counts, winner, winner_valid, overflow
  );
endinterface

// File: rtl/spike_counter.sv
// spike_counter: saturating spike counter with clear and a sticky overflow flag.
module spike_counter
  import spike_rate_decoder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic [CNT_W-1:0] count,
  output logic overflow
);
  logic sat;
  assign sat = &count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      count <= sat ? count : count + CNT_W'(1);
      overflow <= overflow | sat;
    end
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts per-channel spikes over a window and reports counts and the most active channel.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input logic clk,
  input logic reset,
  spike_rate_decoder_if.slave bus
);
  state_t state, state_n;
  logic [WIN_W-1:0] win_cnt;
  logic [NCH-1:0][CNT_W-1:0] cnt;
  logic [NCH-1:0] ovf;
  logic [1:0] winner, best;
  logic [CNT_W-1:0] best_cnt;
  logic winner_valid, go, counting, finish;
  assign go = state == IDLE && bus.start && bus.window_len != '0;
  assign counting = state == COUNT && win_cnt != '0;
  // one settle cycle after the last counted edge so the winner sees final counts
  assign finish = state == COUNT && win_cnt == '0;
  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      spike_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .reset(reset),
        .clr(go),
        .inc(counting && bus.spike_in[g]),
        .count(cnt[g]),
        .overflow(ovf[g])
      );
    end
  endgenerate
  always_comb begin
    best = '0;
    best_cnt = cnt[0];
    for (int i = 1; i < NCH; i++)
      if (cnt[i] > best_cnt) begin
        best = 2'(i);
        best_cnt = cnt[i];
      end
  end
  always_comb begin
    state_n = go ? COUNT :
              finish ? REPORT :
              (state == REPORT && bus.result_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      win_cnt <= '0;
      winner <= '0;
      winner_valid <= 1'b0;
    end else begin
      state <= state_n;
      win_cnt <= go ? bus.window_len : counting ? win_cnt - WIN_W'(1) : win_cnt;
      if (go) begin
        winner <= '0;
        winner_valid <= 1'b0;
      end else if (finish) begin
        winner <= best;
        winner_valid <= |cnt;
      end
    end
  assign bus.busy = state != IDLE;
  assign bus.result_valid = state == REPORT;
  assign bus.counts = cnt;
  assign bus.overflow = ovf;
  assign bus.winner = winner;
  assign bus.winner_valid = winner_valid;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench; expected window results queued at stimulus, checked at report.
module tb_spike_rate_decoder;
  typedef struct {
    logic [23:0] counts;
    logic [1:0] winner;
    logic wv;
    logic [3:0] ovf;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  spike_rate_decoder_if #(.NCH(4), .CNT_W(6), .WIN_W(8)) bus ();
  spike_rate_decoder #(.NCH(4), .CNT_W(6), .WIN_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int mode, input int k);
    case (mode)
      0: return 4'b0001;
      1: return k < 6 ? ((k % 2 == 0) ? 4'b0010 : 4'b0100) : (k == 6 ? 4'b1000 : 4'b0000);
      2: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic drive_window(input int wl, input int mode);
    int c[4] = '{0, 0, 0, 0};
    exp_t e;
    logic [3:0] p;
    int w;
    e.ovf = '0;
    bus.start = 1'b1;
    bus.window_len = 8'(wl);
    bus.spike_in = 4'hF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < wl; k++) begin
      p = pat(mode, k);
      bus.spike_in = p;
      for (int ch = 0; ch < 4; ch++)
        if (p[ch]) begin
          if (c[ch] == 63) e.ovf[ch] = 1'b1;
          else c[ch]++;
        end
      @(posedge clk); #1;
    end
    bus.spike_in = 4'hF;
    w = 0;
    for (int ch = 1; ch < 4; ch++) if (c[ch] > c[w]) w = ch;
    for (int ch = 0; ch < 4; ch++) e.counts[ch*6 +: 6] = 6'(c[ch]);
    e.wv = (c[0] + c[1] + c[2] + c[3]) != 0;
    e.winner = e.wv ? 2'(w) : 2'd0;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.result_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout result_valid=%b want 1", name, bus.result_valid);
    end
  endtask

  task automatic test_reset;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.result_valid, bus.counts, bus.winner, bus.winner_valid, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b rv=%b counts=%h winner=%0d wv=%b ovf=%b want all 0",
               bus.busy, bus.result_valid, bus.counts, bus.winner, bus.winner_valid, bus.overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    drive_window(10, 0);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_early rv=%b busy=%b want rv=0 busy=1", bus.result_valid, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency rv=%b want 1", bus.result_valid);
    end
    e = sb.pop_front();
    checks++;
    if (bus.counts !== e.counts || bus.winner !== e.winner || bus.winner_valid !== e.wv || bus.overflow !== e.ovf) begin
      errors++;
      $display("FAIL single_result counts=%h winner=%0d wv=%b ovf=%b want %h %0d %b %b",
               bus.counts, bus.winner, bus.winner_valid, bus.overflow, e.counts, e.winner, e.wv, e.ovf);
    end
    checks++;
    if (bus.counts[5:0] !== 6'd10 || bus.winner_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_ch0 count=%0d wv=%b want 10 1", bus.counts[5:0], bus.winner_valid);
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.spike_in = '0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_accept busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_tie;
    exp_t e;
    drive_window(8, 1);
    wait_valid("tie");
    e = sb.pop_front();
    checks++;
    if (bus.counts !== e.counts || bus.winner !== e.winner || bus.winner_valid !== e.wv || bus.overflow !== e.ovf) begin
      errors++;
      $display("FAIL tie_result counts=%h winner=%0d wv=%b ovf=%b want %h %0d %b %b",
               bus.counts, bus.winner, bus.winner_valid, bus.overflow, e.counts, e.winner, e.wv, e.ovf);
    end
    checks++;
    if (bus.winner !== 2'd1 || bus.counts[11:6] !== 6'd3 || bus.counts[17:12] !== 6'd3) begin
      errors++;
      $display("FAIL tie_lowest winner=%0d c1=%0d c2=%0d want 1 3 3", bus.winner, bus.counts[11:6], bus.counts[17:12]);
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.spike_in = '0;
  endtask

  task automatic test_saturate;
    exp_t e;
    drive_window(100, 2);
    wait_valid("sat");
    e = sb.pop_front();
    checks++;
    if (bus.counts !== e.counts || bus.winner !== e.winner || bus.winner_valid !== e.wv || bus.overflow !== e.ovf) begin
      errors++;
      $display("FAIL sat_result counts=%h winner=%0d wv=%b ovf=%b want %h %0d %b %b",
               bus.counts, bus.winner, bus.winner_valid, bus.overflow, e.counts, e.winner, e.wv, e.ovf);
    end
    checks++;
    if (bus.counts[23:18] !== 6'd63 || bus.overflow !== 4'b1000) begin
      errors++;
      $display("FAIL sat_ch3 count=%0d ovf=%b want 63 1000", bus.counts[23:18], bus.overflow);
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.spike_in = '0;
  endtask

  task automatic test_hold;
    exp_t e;
    drive_window(8, 1);
    wait_valid("hold");
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      bus.start = k[0] ? 1'b0 : 1'b1;
      bus.window_len = 8'd7;
      bus.spike_in = 4'hF;
      @(posedge clk); #1;
      checks++;
      if (bus.result_valid !== 1'b1 || bus.busy !== 1'b1 || bus.counts !== e.counts ||
          bus.winner !== e.winner || bus.winner_valid !== e.wv || bus.overflow !== e.ovf) begin
        errors++;
        $display("FAIL hold_cycle%0d rv=%b busy=%b counts=%h winner=%0d ovf=%b want 1 1 %h %0d %b",
                 k, bus.result_valid, bus.busy, bus.counts, bus.winner, bus.overflow, e.counts, e.winner, e.ovf);
      end
    end
    bus.start = 1'b1;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release busy=%b rv=%b want 0 0", bus.busy, bus.result_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.counts !== e.counts || bus.winner !== e.winner || bus.overflow !== e.ovf) begin
      errors++;
      $display("FAIL idle_keep busy=%b counts=%h winner=%0d ovf=%b want 0 %h %0d %b",
               bus.busy, bus.counts, bus.winner, bus.overflow, e.counts, e.winner, e.ovf);
    end
    bus.spike_in = '0;
  endtask

  task automatic test_reset_mid;
    bus.start = 1'b1;
    bus.window_len = 8'd20;
    bus.spike_in = 4'b0011;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.result_valid, bus.counts, bus.winner, bus.winner_valid, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs busy=%b rv=%b counts=%h winner=%0d wv=%b ovf=%b want all 0",
               bus.busy, bus.result_valid, bus.counts, bus.winner, bus.winner_valid, bus.overflow);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b1;
    bus.window_len = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.counts !== '0) begin
        errors++;
        $display("FAIL zero_len%0d busy=%b counts=%h want 0 0", k, bus.busy, bus.counts);
      end
    end
    bus.start = 1'b0;
    bus.spike_in = '0;
  endtask

  task automatic test_empty;
    exp_t e;
    drive_window(5, 3);
    wait_valid("empty");
    e = sb.pop_front();
    checks++;
    if (bus.counts !== e.counts || bus.winner !== e.winner || bus.winner_valid !== e.wv || bus.overflow !== e.ovf) begin
      errors++;
      $display("FAIL empty_result counts=%h winner=%0d wv=%b ovf=%b want %h %0d %b %b",
               bus.counts, bus.winner, bus.winner_valid, bus.overflow, e.counts, e.winner, e.wv, e.ovf);
    end
    checks++;
    if (bus.counts !== '0 || bus.winner !== 2'd0 || bus.winner_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_zero counts=%h winner=%0d wv=%b want 0 0 0", bus.counts, bus.winner, bus.winner_valid);
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.spike_in = '0;
  endtask

  initial begin
    bus.spike_in = '0;
    bus.window_len = '0;
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    test_reset;
    test_single;
    test_tie;
    test_saturate;
    test_hold;
    test_reset_mid;
    test_empty;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
